// File: rtl/log2_pkg.sv
// Shared log2 datapath constants and types, common to the normalizer and the fraction iterator.
package log2_pkg;

  localparam int E_INT_DEF    = 7;
  localparam int D_FRAC_DEF   = 8;
  localparam int OUT_FRAC_DEF = 8;

  localparam int W     = E_INT_DEF + D_FRAC_DEF + 1;
  localparam int EXP_W = $clog2(E_INT_DEF + 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} log2_state_t;

  typedef logic [W-1:0]                  mant_t;
  typedef logic [EXP_W+OUT_FRAC_DEF-1:0] log_t;

endpackage

// File: rtl/square_norm.sv
// Combinational y*y with renormalisation back to 1.f; bit_out is the log2 fraction bit.
// Low product bits are dropped (truncation, no rounding).
module square_norm #(
  parameter int W = 16
) (
  input  logic [W-1:0] y,
  output logic [W-1:0] y_next,
  output logic         bit_out
);

  logic [2*W-1:0] p;
  logic           unused_low;

  assign p          = {{W{1'b0}}, y} * {{W{1'b0}}, y};
  assign bit_out    = p[2*W-1];
  // Product in [2,4) is halved by taking the upper window; [1,2) keeps one more bit.
  assign y_next     = bit_out ? p[2*W-1 -: W] : p[2*W-2 -: W];
  assign unused_low = ^p[W-2:0];

endmodule

// File: rtl/log2_frac_iter.sv
// log2 of a normalized mantissa: {j, fraction} with one fraction bit per clock by squaring.
// Latency OUT_FRAC+1 edges (zero input: 1); single op in flight, result held until out_ready.
module log2_frac_iter
  import log2_pkg::*;
#(
  parameter int   E_int    = E_INT_DEF,
  parameter int   D_frac   = D_FRAC_DEF,
  parameter int   OUT_FRAC = OUT_FRAC_DEF,
  localparam int  MANT_W   = E_int + D_frac + 1,
  localparam int  INT_W    = $clog2(E_int + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MANT_W-1:0]         mant_in,
  input  logic [INT_W-1:0]          exp_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INT_W+OUT_FRAC-1:0] log_out,
  output logic                      zero_err
);

  localparam int CNT_W = $clog2(OUT_FRAC + 1);

  log2_state_t         state, state_nxt;
  logic [MANT_W-1:0]   y, y_next;
  logic                sq_bit;
  logic [INT_W-1:0]    int_q;
  logic [OUT_FRAC-1:0] frac;
  logic [CNT_W-1:0]    cnt;
  logic                zero_q;
  logic                accept;

  square_norm #(.W(MANT_W)) u_square_norm (
    .y       (y),
    .y_next  (y_next),
    .bit_out (sq_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    log_out   = '0;
    zero_err  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = mant_in[MANT_W-1] ? ITER : DONE;
        end
      end
      ITER: begin
        if (cnt == CNT_W'(OUT_FRAC - 1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        log_out   = {int_q, frac};
        zero_err  = zero_q;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y      <= '0;
      int_q  <= '0;
      frac   <= '0;
      cnt    <= '0;
      zero_q <= 1'b0;
    end else if (accept) begin
      frac <= '0;
      cnt  <= '0;
      // A zero mantissa has no leading one: report it and leave the result at 0.
      if (mant_in[MANT_W-1]) begin
        y      <= mant_in;
        int_q  <= exp_in;
        zero_q <= 1'b0;
      end else begin
        y      <= '0;
        int_q  <= '0;
        zero_q <= 1'b1;
      end
    end else if (state == ITER) begin
      y    <= y_next;
      frac <= {frac[OUT_FRAC-2:0], sq_bit};
      cnt  <= cnt + 1'b1;
    end
  end

endmodule
